// File: rtl/xor_decrypt_rx.sv
// Serial ciphertext receiver: deserializes one frame, XORs it with a repeating serial key, re-serializes plaintext.
// Optional XOR_RX_KEY_CLEAR_EN: key and oKey_valid are wiped when a frame completes (one-time key).
module xor_decrypt_rx #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic iKey_in,
    input  logic iKey_flag,
    input  logic iData_in,
    input  logic iData_flag,
    output logic oData_out,
    output logic oData_flag,
    output logic oKey_valid,
    output logic oBusy,
    output logic oError,
    output logic oDone
);
    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam int KW = $clog2(KEY_SIZE) + 1;
    localparam logic [CW-1:0] MSG_CNT  = CW'(MSG_SIZE);
    localparam logic [CW-1:0] MSG_LAST = CW'(MSG_SIZE - 1);
    localparam logic [KW-1:0] KEY_CNT  = KW'(KEY_SIZE);

    typedef enum logic [1:0] {IDLE, RECV, DECRYPT, SEND} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MSG_SIZE-1:0]   ct_q, ct_d;
    logic [MSG_SIZE-1:0]   pt_q, pt_d;
    logic [KEY_SIZE-1:0]   key_q, key_d;
    logic [KW-1:0]         kcnt_q, kcnt_d;
    logic                  key_valid_q, key_valid_d;
    logic                  kflag_prev_q, kflag_prev_d;
    logic                  arm_q, arm_d;
    logic                  out_q, out_d;
    logic                  oflag_q, oflag_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ct_q         <= '0;
            pt_q         <= '0;
            key_q        <= '0;
            kcnt_q       <= '0;
            key_valid_q  <= 1'b0;
            kflag_prev_q <= 1'b0;
            arm_q        <= 1'b0;
            out_q        <= 1'b0;
            oflag_q      <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else if (ena) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ct_q         <= ct_d;
            pt_q         <= pt_d;
            key_q        <= key_d;
            kcnt_q       <= kcnt_d;
            key_valid_q  <= key_valid_d;
            kflag_prev_q <= kflag_prev_d;
            arm_q        <= arm_d;
            out_q        <= out_d;
            oflag_q      <= oflag_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ct_d         = ct_q;
        pt_d         = pt_q;
        key_d        = key_q;
        kcnt_d       = kcnt_q;
        key_valid_d  = key_valid_q;
        kflag_prev_d = iKey_flag;
        arm_d        = arm_q;
        out_d        = 1'b0;
        oflag_d      = 1'b0;
        err_d        = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                // a frame may only start after the data flag has been seen low here
                if (!iData_flag) begin
                    arm_d = 1'b1;
                end else if (arm_q) begin
                    ct_d    = {ct_q[MSG_SIZE-2:0], iData_in};
                    cnt_d   = CW'(1);
                    arm_d   = 1'b0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (iData_flag) begin
                    ct_d  = {ct_q[MSG_SIZE-2:0], iData_in};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == MSG_LAST) state_d = DECRYPT;
                end else begin
                    err_d   = 1'b1;
                    ct_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            DECRYPT: begin
                cnt_d = '0;
                if (!key_valid_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    pt_d    = ct_q ^ {(MSG_SIZE / KEY_SIZE){key_q}};
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cnt_q != MSG_CNT) begin
                    out_d   = pt_q[MSG_SIZE-1];
                    oflag_d = 1'b1;
                    pt_d    = {pt_q[MSG_SIZE-2:0], 1'b0};
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != DECRYPT && state_q != SEND) begin
            if (iKey_flag) key_d = {key_q[KEY_SIZE-2:0], iKey_in};
            if (iKey_flag && !kflag_prev_q) begin
                kcnt_d      = KW'(1);
                key_valid_d = 1'b0;
            end else begin
                if (iKey_flag && kcnt_q != KEY_CNT) kcnt_d = kcnt_q + KW'(1);
                if (kcnt_q == KEY_CNT) key_valid_d = 1'b1;
            end
        end

`ifdef XOR_RX_KEY_CLEAR_EN
        // counter must clear too, otherwise valid would re-assert from the saturated count
        if (done_d) begin
            key_d       = '0;
            kcnt_d      = '0;
            key_valid_d = 1'b0;
        end
`else
`endif
    end

    assign oData_out  = out_q;
    assign oData_flag = oflag_q;
    assign oKey_valid = key_valid_q;
    assign oBusy      = (state_q != IDLE);
    assign oError     = err_q;
    assign oDone      = done_q;
endmodule

// File: tb/tb_xor_decrypt_rx.sv
// Scoreboard bench for xor_decrypt_rx: driver queues expected frames/errors, a negedge monitor checks them.
module tb_xor_decrypt_rx;
    logic clk, rst_n, ena;
    logic iKey_in, iKey_flag, iData_in, iData_flag;
    logic oData_out, oData_flag, oKey_valid, oBusy, oError, oDone;

    xor_decrypt_rx #(.MSG_SIZE(64), .KEY_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .iKey_in(iKey_in), .iKey_flag(iKey_flag),
        .iData_in(iData_in), .iData_flag(iData_flag),
        .oData_out(oData_out), .oData_flag(oData_flag),
        .oKey_valid(oKey_valid), .oBusy(oBusy),
        .oError(oError), .oDone(oDone)
    );

    typedef struct packed {
        logic        is_err;
        logic [63:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          edge_cnt = 0;
    int          last_in_edge = 0;
    logic        ena_e = 1'b0;

    localparam logic [63:0] CT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] PT1 = 64'hAD8FE9CB25076143;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // edge bookkeeping: which edges were enabled, and the last edge that sampled a ciphertext bit
    initial forever begin
        @(posedge clk);
        edge_cnt++;
        ena_e = ena;
        if (rst_n && ena && iData_flag) last_in_edge = edge_cnt;
    end

    initial begin : monitor
        logic [63:0] got;
        int          nbits;
        int          lat;
        logic        last_out;
        exp_t        e;
        got = '0; nbits = 0; lat = 0; last_out = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nbits = 0;
                got   = '0;
            end else if (ena_e) begin
                if (oData_flag) begin
                    if (nbits == 0) lat = edge_cnt - last_in_edge;
                    got = {got[62:0], oData_out};
                    nbits++;
                end
                if (oDone) begin
                    if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                    else begin
                        e = sb.pop_front();
                        check("done_kind", {63'd0, e.is_err}, 64'd0);
                        check("plaintext", got, e.data);
                        check("bit_count", 64'(nbits), 64'd64);
                        check("latency", 64'(lat), 64'd2);
                    end
                    nbits = 0;
                end
                if (oError) begin
                    if (sb.size() == 0) check("unexpected_error", 64'd1, 64'd0);
                    else begin
                        e = sb.pop_front();
                        check("error_kind", {63'd0, e.is_err}, 64'd1);
                        check("error_no_output", 64'(nbits), 64'd0);
                    end
                    nbits = 0;
                end
            end else if (oData_flag) begin
                check("frozen_out", {63'd0, oData_out}, {63'd0, last_out});
            end
            last_out = oData_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            iKey_flag = 1'b1;
            iKey_in   = k[7-i];
            tick();
        end
        iKey_flag = 1'b0;
        iKey_in   = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(input logic [63:0] ct, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            iData_flag = 1'b1;
            iData_in   = ct[63-i];
            tick();
        end
        iData_flag = 1'b0;
        iData_in   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!oBusy) break;
            tick();
        end
        check("idle_timeout", {63'd0, oBusy}, 64'd0);
        tick();
        tick();
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {58'd0, oData_out, oData_flag, oKey_valid, oBusy, oError, oDone}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1;
        iKey_in = 1'b0; iKey_flag = 1'b0; iData_in = 1'b0; iData_flag = 1'b0;
        tick(); tick(); tick();
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        tick(); tick();

        // basic decrypt
        load_key(8'hAC);
        check("key_valid", {63'd0, oKey_valid}, 64'd1);
        sb.push_back('{is_err: 1'b0, data: PT1});
        send_frame(CT1, 64);
        check("busy_decrypt", {63'd0, oBusy}, 64'd1);
        wait_idle();

        // truncated frame then a good one
        sb.push_back('{is_err: 1'b1, data: 64'd0});
        send_frame(CT1, 40);
        wait_idle();
        check("idle_after_short", {63'd0, oBusy}, 64'd0);
        load_key(8'hAC);
        sb.push_back('{is_err: 1'b0, data: PT1});
        send_frame(CT1, 64);
        wait_idle();

        // no key after reset
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick(); tick();
        check("no_key_valid", {63'd0, oKey_valid}, 64'd0);
        sb.push_back('{is_err: 1'b1, data: 64'd0});
        send_frame(CT1, 64);
        wait_idle();

        // enable gap mid-SEND
        load_key(8'hFF);
        sb.push_back('{is_err: 1'b0, data: 64'h00000000FFFFFFFF});
        send_frame(64'hFFFFFFFF00000000, 64);
        for (int i = 0; i < 20; i++) tick();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("busy_held_gap", {63'd0, oBusy}, 64'd1);
        ena = 1'b1;
        wait_idle();

        // reset at plaintext bit 30
        load_key(8'hAC);
        send_frame(CT1, 64);
        for (int i = 0; i < 31; i++) tick();
        check("flag_before_reset", {63'd0, oData_flag}, 64'd1);
        rst_n = 1'b0;
        tick();
        check_outputs_zero("mid_frame_reset");
        rst_n = 1'b1;
        tick(); tick();
        load_key(8'hAC);
        sb.push_back('{is_err: 1'b0, data: PT1});
        send_frame(CT1, 64);
        wait_idle();

        // key reload during SEND is ignored
        load_key(8'hAC);
        sb.push_back('{is_err: 1'b0, data: PT1});
        send_frame(CT1, 64);
        for (int i = 0; i < 10; i++) tick();
        load_key(8'h55);
        wait_idle();
`ifdef XOR_RX_KEY_CLEAR_EN
        check("key_cleared", {63'd0, oKey_valid}, 64'd0);
        sb.push_back('{is_err: 1'b1, data: 64'd0});
`else
        check("key_persist", {63'd0, oKey_valid}, 64'd1);
        sb.push_back('{is_err: 1'b0, data: PT1});
`endif
        send_frame(CT1, 64);
        wait_idle();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
